// File: rtl/ita_package.sv
`default_nettype none
// ============================================================================
// Package : ita_package
// Purpose : Shared types, constants and helpers for the ITA tile sequencer.
//           Layer/step encodings, the control-register view, tile index type
//           and the step-to-requant-constant mapping.
// Rev     : 1.0
// ============================================================================
package ita_package;

  localparam int unsigned H                = 1;
  localparam int unsigned N_REQUANT_CONSTS = 8;
  localparam int unsigned REQ_W            = (N_REQUANT_CONSTS > 1) ? $clog2(N_REQUANT_CONSTS) : 1;

  typedef logic [31:0]      tile_t;
  typedef tile_t            tile_idx_t;
  typedef logic [REQ_W-1:0] req_idx_t;

  typedef enum logic [1:0] {
    Attention, SingleAttention, Feedforward, Linear
  } layer_e;

  typedef enum logic [3:0] {
    Idle, Q, K, V, QK, AV, OW, F1, F2, MatMul
  } step_e;

  typedef struct packed {
    logic   start;
    layer_e layer;
    tile_t  tile_s;
    tile_t  tile_e;
    tile_t  tile_p;
    tile_t  tile_f;
  } ctrl_t;

  // Width of an index able to address n items (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Requant constant set used by each step; MatMul shares slot 0 with Q.
  function automatic req_idx_t step_req_idx(input step_e s);
    req_idx_t r;
    case (s)
      K:       r = req_idx_t'(1);
      V:       r = req_idx_t'(2);
      QK:      r = req_idx_t'(3);
      AV:      r = req_idx_t'(4);
      OW:      r = req_idx_t'(5);
      F1:      r = req_idx_t'(6);
      F2:      r = req_idx_t'(7);
      default: r = req_idx_t'(0);
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ita_tile_loop_counter.sv
`default_nettype none
// ============================================================================
// Module  : ita_tile_loop_counter
// Purpose : Three nested tile counters (row > col > inner, inner fastest).
//           Each advance_i steps the inner counter; carries ripple outward.
//           After the final tile of the nest all counters return to zero.
// Ports   : clk_i, rst_i     - clock, synchronous active-high reset
//           advance_i        - step to the next tile (a transfer happened)
//           bound_*_i        - loop bounds, must be >= 1
//           row_o/col_o/inner_o - current indices
//           first_o / last_o - inner index is first / last
//           wrap_o           - current tile is the last of the whole nest
// Rev     : 1.0
// ============================================================================
module ita_tile_loop_counter
  import ita_package::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      advance_i,
  input  tile_t     bound_row_i,
  input  tile_t     bound_col_i,
  input  tile_t     bound_inner_i,
  output tile_idx_t row_o,
  output tile_idx_t col_o,
  output tile_idx_t inner_o,
  output logic      first_o,
  output logic      last_o,
  output logic      wrap_o
);

  tile_idx_t row_q, row_d;
  tile_idx_t col_q, col_d;
  tile_idx_t inner_q, inner_d;
  logic      row_last, col_last, inner_last;

  assign row_last   = (row_q   == bound_row_i   - 32'd1);
  assign col_last   = (col_q   == bound_col_i   - 32'd1);
  assign inner_last = (inner_q == bound_inner_i - 32'd1);

  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    inner_d = inner_q;
    if (advance_i) begin
      if (inner_last) begin
        inner_d = '0;
        if (col_last) begin
          col_d = '0;
          row_d = row_last ? '0 : row_q + 32'd1;
        end else begin
          col_d = col_q + 32'd1;
        end
      end else begin
        inner_d = inner_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_q   <= '0;
      col_q   <= '0;
      inner_q <= '0;
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      inner_q <= inner_d;
    end
  end

  assign row_o   = row_q;
  assign col_o   = col_q;
  assign inner_o = inner_q;
  assign first_o = (inner_q == '0);
  assign last_o  = inner_last;
  assign wrap_o  = inner_last & col_last & row_last;

endmodule
`default_nettype wire

// File: rtl/ita_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : ita_step_sequencer
// Purpose : Tile-loop controller. Latches the layer configuration on start,
//           walks the step sequence of the layer (per head for Attention)
//           and issues one tile descriptor per cycle over valid/ready.
// Ports   : clk_i, rst_i          - clock, synchronous active-high reset
//           ctrl_i                - start, layer and tile counts (Idle only)
//           tile_valid_o/ready_i  - descriptor handshake
//           step_o, head_o        - current step / head
//           row_o, col_o, inner_o - current tile indices
//           inner_first_o/last_o  - accumulator clear / requantize markers
//           req_idx_o             - requant constant index
//           busy_o, done_o        - activity flag, completion pulse
// Rev     : 1.0
// ============================================================================
module ita_step_sequencer
  import ita_package::*;
#(
  parameter int unsigned H = ita_package::H
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  ctrl_t                   ctrl_i,
  output logic                    tile_valid_o,
  input  logic                    tile_ready_i,
  output step_e                   step_o,
  output logic [idx_width(H)-1:0] head_o,
  output tile_idx_t               row_o,
  output tile_idx_t               col_o,
  output tile_idx_t               inner_o,
  output logic                    inner_first_o,
  output logic                    inner_last_o,
  output req_idx_t                req_idx_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int unsigned HW = idx_width(H);
  localparam logic [HW-1:0] HEAD_LAST = HW'(H - 1);

  step_e         state_q, state_d;
  logic [HW-1:0] head_q, head_d;
  layer_e        layer_q, layer_d;
  tile_t         ts_q, ts_d, te_q, te_d, tp_q, tp_d, tf_q, tf_d;
  logic          done_q, done_d;
  logic          advance, wrap, busy, first, last;
  tile_t         b_row, b_col, b_inner;

  // A zero tile count still means one tile.
  function automatic tile_t nz(input tile_t b);
    return (b == '0) ? 32'd1 : b;
  endfunction

  assign busy = (state_q != Idle);

  // Loop bounds for the step currently being walked.
  always_comb begin
    b_row   = nz(ts_q);
    b_col   = 32'd1;
    b_inner = 32'd1;
    case (state_q)
      Q, K, V, MatMul: begin b_col = nz(tp_q); b_inner = nz(te_q); end
      QK:              begin b_col = nz(ts_q); b_inner = nz(tp_q); end
      AV:              begin b_col = nz(tp_q); b_inner = nz(ts_q); end
      OW:              begin b_col = nz(te_q); b_inner = nz(tp_q); end
      F1:              begin b_col = nz(tf_q); b_inner = nz(te_q); end
      F2:              begin b_col = nz(te_q); b_inner = nz(tf_q); end
      default:         b_row = 32'd1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    layer_d = layer_q;
    ts_d    = ts_q;
    te_d    = te_q;
    tp_d    = tp_q;
    tf_d    = tf_q;
    done_d  = 1'b0;
    advance = 1'b0;
    if (!busy) begin
      if (ctrl_i.start) begin
        layer_d = ctrl_i.layer;
        ts_d    = ctrl_i.tile_s;
        te_d    = ctrl_i.tile_e;
        tp_d    = ctrl_i.tile_p;
        tf_d    = ctrl_i.tile_f;
        head_d  = '0;
        case (ctrl_i.layer)
          Feedforward: state_d = F1;
          Linear:      state_d = MatMul;
          default:     state_d = Q;
        endcase
      end
    end else if (tile_ready_i) begin
      // Valid is always high while busy, so ready alone marks a transfer.
      advance = 1'b1;
      if (wrap) begin
        case (state_q)
          Q:  state_d = K;
          K:  state_d = V;
          V:  state_d = QK;
          QK: state_d = AV;
          AV: state_d = OW;
          F1: state_d = F2;
          OW: begin
            if (layer_q == Attention && head_q != HEAD_LAST) begin
              head_d  = head_q + 1'b1;
              state_d = Q;
            end else begin
              head_d  = '0;
              state_d = Idle;
              done_d  = 1'b1;
            end
          end
          default: begin
            head_d  = '0;
            state_d = Idle;
            done_d  = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= Idle;
      head_q  <= '0;
      layer_q <= Attention;
      ts_q    <= '0;
      te_q    <= '0;
      tp_q    <= '0;
      tf_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      layer_q <= layer_d;
      ts_q    <= ts_d;
      te_q    <= te_d;
      tp_q    <= tp_d;
      tf_q    <= tf_d;
      done_q  <= done_d;
    end
  end

  ita_tile_loop_counter u_loop (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .advance_i     (advance),
    .bound_row_i   (b_row),
    .bound_col_i   (b_col),
    .bound_inner_i (b_inner),
    .row_o         (row_o),
    .col_o         (col_o),
    .inner_o       (inner_o),
    .first_o       (first),
    .last_o        (last),
    .wrap_o        (wrap)
  );

  assign tile_valid_o  = busy;
  assign busy_o        = busy;
  assign step_o        = state_q;
  assign head_o        = head_q;
  assign inner_first_o = busy & first;
  assign inner_last_o  = busy & last;
  assign req_idx_o     = step_req_idx(state_q);
  assign done_o        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ita_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_ita_step_sequencer
// Purpose : Self-checking bench for ita_step_sequencer. A reference model
//           expands each layer configuration into the full list of expected
//           descriptors; the DUT output is compared against it transfer by
//           transfer under several ready patterns.
// Rev     : 1.0
// ============================================================================
module tb_ita_step_sequencer;
  import ita_package::*;

  localparam int TB_H = 2;
  localparam int HW   = idx_width(TB_H);

  logic            clk = 1'b0;
  logic            rst_i;
  ctrl_t           ctrl_i;
  logic            tile_valid_o, tile_ready_i;
  step_e           step_o;
  logic [HW-1:0]   head_o;
  tile_idx_t       row_o, col_o, inner_o;
  logic            inner_first_o, inner_last_o, busy_o, done_o;
  req_idx_t        req_idx_o;

  always #5 clk = ~clk;

  ita_step_sequencer #(.H(TB_H)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .ctrl_i        (ctrl_i),
    .tile_valid_o  (tile_valid_o),
    .tile_ready_i  (tile_ready_i),
    .step_o        (step_o),
    .head_o        (head_o),
    .row_o         (row_o),
    .col_o         (col_o),
    .inner_o       (inner_o),
    .inner_first_o (inner_first_o),
    .inner_last_o  (inner_last_o),
    .req_idx_o     (req_idx_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  typedef struct packed {
    step_e         step;
    logic [HW-1:0] head;
    tile_t         row;
    tile_t         col;
    tile_t         inner;
    logic          first;
    logic          last;
    req_idx_t      req;
  } desc_t;

  typedef struct {
    layer_e layer;
    int     s, e, p, f;
    int     mode;      // 0 ready high, 1 random, 2 stall 3 cycles, 3 random + start poke
    int     exp_xfer;
  } vec_t;

  desc_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic req_idx_t ref_req(input step_e s);
    case (s)
      Q: return 0;  K: return 1;  V: return 2;  QK: return 3;
      AV: return 4; OW: return 5; F1: return 6; F2: return 7;
      default: return 0;
    endcase
  endfunction

  function automatic int nz(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  // Expand a configuration into every descriptor it must produce, in order.
  task automatic build_model(input layer_e l, input int s, e, p, f);
    step_e seq[$];
    int    nh, cb, ib;
    desc_t d;
    exp_q.delete();
    case (l)
      Attention, SingleAttention: seq = '{Q, K, V, QK, AV, OW};
      Feedforward:                seq = '{F1, F2};
      default:                    seq = '{MatMul};
    endcase
    nh = (l == Attention) ? TB_H : 1;
    for (int h = 0; h < nh; h++) begin
      foreach (seq[si]) begin
        case (seq[si])
          QK:      begin cb = nz(s); ib = nz(p); end
          AV:      begin cb = nz(p); ib = nz(s); end
          OW:      begin cb = nz(e); ib = nz(p); end
          F1:      begin cb = nz(f); ib = nz(e); end
          F2:      begin cb = nz(e); ib = nz(f); end
          default: begin cb = nz(p); ib = nz(e); end
        endcase
        for (int r = 0; r < nz(s); r++)
          for (int c = 0; c < cb; c++)
            for (int i = 0; i < ib; i++) begin
              d.step  = seq[si];
              d.head  = HW'(h);
              d.row   = tile_t'(r);
              d.col   = tile_t'(c);
              d.inner = tile_t'(i);
              d.first = (i == 0);
              d.last  = (i == ib - 1);
              d.req   = ref_req(seq[si]);
              exp_q.push_back(d);
            end
      end
    end
  endtask

  function automatic desc_t dut_desc();
    desc_t d;
    d.step = step_o; d.head = head_o; d.row = row_o; d.col = col_o; d.inner = inner_o;
    d.first = inner_first_o; d.last = inner_last_o; d.req = req_idx_o;
    return d;
  endfunction

  task automatic chk_idle(input string name);
    chk(name, {tile_valid_o, busy_o, done_o, step_o, head_o, row_o, col_o, inner_o,
               inner_first_o, inner_last_o, req_idx_o}, '0);
  endtask

  // Called at a negedge; issues start in this cycle and returns at the
  // negedge where done_o is checked (so a following call starts in the
  // done cycle), or after a mid-run reset has been checked.
  task automatic run_layer(input layer_e l, input int s, e, p, f, input int mode,
                           input bit rst_qk, output int n_xfer, output int n_exp);
    int cyc   = 0;
    int stall = 0;
    bit fin   = 0;
    bit expect_done = 0;
    bit rdy;
    n_xfer = 0;
    build_model(l, s, e, p, f);
    n_exp = exp_q.size();
    ctrl_i.start  = 1'b1;
    ctrl_i.layer  = l;
    ctrl_i.tile_s = tile_t'(s);
    ctrl_i.tile_e = tile_t'(e);
    ctrl_i.tile_p = tile_t'(p);
    ctrl_i.tile_f = tile_t'(f);
    tile_ready_i  = 1'b0;
    @(negedge clk);
    // Scramble the configuration: it must have been latched already.
    ctrl_i.start  = 1'b0;
    ctrl_i.layer  = layer_e'(2'($urandom_range(0, 3)));
    ctrl_i.tile_s = tile_t'($urandom_range(0, 7));
    ctrl_i.tile_e = tile_t'($urandom_range(0, 7));
    ctrl_i.tile_p = tile_t'($urandom_range(0, 7));
    ctrl_i.tile_f = tile_t'($urandom_range(0, 7));
    chk("start_busy", {busy_o, tile_valid_o}, 2'b11);
    while (!fin) begin
      cyc++;
      if (cyc > 5000) begin
        total++; bad++;
        $display("FAIL timeout: got no done after %0d cycles, required done", cyc);
        fin = 1;
      end else if (expect_done) begin
        chk("done_pulse", {done_o, busy_o, tile_valid_o}, 3'b100);
        fin = 1;
      end else begin
        chk("no_early_done", done_o, 1'b0);
        if (rst_qk && step_o == QK) begin
          rst_i = 1'b1;
          tile_ready_i = 1'b0;
          @(negedge clk);
          rst_i = 1'b0;
          chk_idle("reset_mid_op");
          repeat (4) begin
            @(negedge clk);
            chk("no_done_after_reset", {done_o, busy_o}, 2'b00);
          end
          fin = 1;
        end else if (!tile_valid_o) begin
          chk("valid_held", tile_valid_o, 1'b1);
          fin = 1;
        end else begin
          if (exp_q.size() == 0) chk("extra_descriptor", tile_valid_o, 1'b0);
          else chk("descriptor", dut_desc(), exp_q[0]);
          case (mode)
            0:       rdy = 1'b1;
            2:       rdy = !(n_xfer == 2 && stall < 3);
            default: rdy = ($urandom_range(0, 2) != 0);
          endcase
          if (mode == 2 && !rdy) stall++;
          if (mode == 3 && n_xfer == 1) begin
            ctrl_i.start  = 1'b1;
            ctrl_i.tile_s = ctrl_i.tile_s + 32'd3;
          end else begin
            ctrl_i.start = 1'b0;
          end
          tile_ready_i = rdy;
          if (rdy) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            n_xfer++;
            if (exp_q.size() == 0) expect_done = 1;
          end
          @(negedge clk);
        end
      end
    end
    ctrl_i.start = 1'b0;
    tile_ready_i = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   n, ne;
    vecs[0] = '{Feedforward,     1, 2, 0, 1, 0, 4};
    vecs[1] = '{SingleAttention, 1, 1, 1, 1, 0, 6};
    vecs[2] = '{Linear,          2, 0, 1, 0, 0, 2};
    vecs[3] = '{Attention,       1, 1, 1, 1, 1, 12};
    vecs[4] = '{Feedforward,     2, 1, 0, 3, 1, 12};
    vecs[5] = '{Linear,          1, 3, 2, 0, 2, 6};
    vecs[6] = '{Attention,       1, 2, 1, 0, 3, 20};

    rst_i = 1'b1;
    ctrl_i = '0;
    tile_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset_state");
    rst_i = 1'b0;
    @(negedge clk);
    chk_idle("idle_after_reset");

    // Back-to-back directed runs; each start lands in the previous done cycle.
    for (int k = 0; k < 7; k++) begin
      run_layer(vecs[k].layer, vecs[k].s, vecs[k].e, vecs[k].p, vecs[k].f,
                vecs[k].mode, 1'b0, n, ne);
      chk("xfer_count", n, vecs[k].exp_xfer);
    end
    @(negedge clk);
    chk("done_one_cycle", done_o, 1'b0);

    // Reset during QK, then a fresh complete run.
    run_layer(Attention, 1, 1, 2, 0, 1, 1'b1, n, ne);
    run_layer(Attention, 1, 1, 2, 0, 1, 1'b0, n, ne);
    chk("xfer_count_after_reset", n, 24);
    @(negedge clk);

    for (int k = 0; k < 30; k++) begin
      run_layer(layer_e'(2'($urandom_range(0, 3))), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 1), 1'b0, n, ne);
      chk("rand_xfer_count", n, ne);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
    chk_idle("final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ita_step_sequencer.md
# ita_step_sequencer

Tile-loop controller for the ITA datapath. On `start` it latches the layer configuration, then walks the required step sequence (Q…OW, F1/F2, or MatMul) and, within each step, a three-level tile loop (row, col, inner). It issues one tile descriptor per cycle to the datapath over a valid/ready handshake and pulses `done_o` when the layer completes. It sits between the control/register interface (`ctrl_t`) and the accumulator/requantizer datapath.

## Interface
- `H`, default `ita_package::H`: number of heads iterated for `Attention`.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `ctrl_i`  in  `ctrl_t`  configuration. Only `start`, `layer`, `tile_s`, `tile_e`, `tile_p` and `tile_f` are used. Sampled only in Idle.
- `tile_valid_o`  out  1  descriptor valid.
- `tile_ready_i`  in  1  datapath accepts the descriptor.
- `step_o`  out  `step_e`  current step. `Idle` when not busy.
- `head_o`  out  `idx_width(H)`  current head.
- `row_o`, `col_o`, `inner_o`  out  `tile_t` each  current tile indices.
- `inner_first_o`  out  1  `inner_o == 0`. Datapath loads bias / clears the accumulator.
- `inner_last_o`  out  1  last inner tile. Datapath requantizes and writes out.
- `req_idx_o`  out  `idx_width(N_REQUANT_CONSTS)`  requant constant index.
- `busy_o`  out  1  not Idle.
- `done_o`  out  1  one-cycle completion pulse.

## Operation
**States.** The FSM state is `step_e`.

**Step sequence by layer:**
- `Attention`: for h = 0..H-1, run Q, K, V, QK, AV, OW.
- `SingleAttention`: Q, K, V, QK, AV, OW once, with h = 0.
- `Feedforward`: F1, F2.
- `Linear`: MatMul.

**Loop bounds (rows × cols × inner):**
- Q/K/V: `tile_s` × `tile_p` × `tile_e`.
- QK: `tile_s` × `tile_s` × `tile_p`.
- AV: `tile_s` × `tile_p` × `tile_s`.
- OW: `tile_s` × `tile_e` × `tile_p`.
- F1: `tile_s` × `tile_f` × `tile_e`.
- F2: `tile_s` × `tile_e` × `tile_f`.
- MatMul: `tile_s` × `tile_p` × `tile_e`.
- A bound of 0 is treated as 1.

**Loop order.** Inner is the fastest loop, then col, then row. The step changes after the last row, and the head changes after OW.

**Requant index (`req_idx_o`):** Q=0, K=1, V=2, QK=3, AV=4, OW=5, F1=6, F2=7, MatMul=0. Idle drives 0.

**Configuration latch.** `layer` and all tile fields are latched in the cycle `start` is seen in Idle. Later changes to `ctrl_i` have no effect until the next start.

**Boundary conditions:**
- `start` while busy is ignored.
- Counter comparisons use the latched 32-bit bounds. No wrap-around is possible within a bound.
- A reset while busy returns to Idle the next edge, and `done_o` is not asserted.

## Timing
**Reset values.** All outputs are 0, `step_o = Idle`.

**Start.**
- Cycle t: `ctrl_i.start = 1` in Idle.
- Cycle t+1: `busy_o = 1`, `tile_valid_o = 1`, first step of the sequence, all indices 0.

**Handshake.**
- A transfer occurs on any edge where `tile_valid_o && tile_ready_i`. The counters advance on that edge.
- The next descriptor is presented the following cycle with no bubble, including across step and head boundaries.
- While `tile_ready_i = 0`, all descriptor outputs hold stable. `tile_valid_o` never drops without a transfer.

**Completion.**
- On the edge of the final transfer, the FSM goes to Idle.
- In the next cycle: `done_o = 1` for one cycle, `busy_o = 0`, `tile_valid_o = 0`.

**New start.** A `start` in that same done cycle is accepted.

**Throughput.** One tile per cycle with `tile_ready_i` tied high.

## Structure
**Package (`ita_package`).** Reuse `ctrl_t`, `step_e`, `layer_e`, `tile_t` and `N_REQUANT_CONSTS`. Add these to the package:
- `tile_idx_t`, an alias of `tile_t`.
- A function `step_req_idx(step_e)` implementing the requant index mapping.

**Sub-module `ita_tile_loop_counter`.** This is the natural split.
- Contents: three nested counters with bounds, an advance input, `first`/`last` flags and a `wrap` output.
- The top level owns the step/head FSM, the bound selection per step, and the `done` pulse.

## Test plan
- **Feedforward.** `tile_s=1`, `tile_e=2`, `tile_f=1`, ready high → 4 transfers:
  - F1(inner 0, 1), then F2(col 0, 1), with `req_idx` 6, 6, 7, 7.
  - `done_o` pulses 1 cycle after the 4th transfer.
- **Attention.** H=1, all tiles = 1 → 6 transfers in order Q, K, V, QK, AV, OW with `req_idx` 0..5. Each transfer has `inner_first_o = inner_last_o = 1`.
- **Backpressure.** Hold ready low for 3 cycles mid-step → the descriptor is stable across those cycles and no counter advances. The transfer count equals the bound product.
- **Zero bound.** Linear with `tile_e=0`, `tile_s=2`, `tile_p=1` → 2 MatMul transfers (row 0, 1), `inner_last_o = 1` on each.
- **Ignored start and config change.** Pulse `start` and change `tile_s` while busy → the sequence and transfer count are unchanged, with exactly one `done_o`.
- **Reset mid-operation.** Assert `rst_i` during QK → the next cycle shows all outputs at 0 and `step_o = Idle`. No `done_o` occurs, and a fresh start runs a full sequence.
